// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the multi-port register file with dump engine.
//   DEFAULT_DATA_WIDTH / DEFAULT_ADDR_WIDTH : default geometry of the block
//   dump_state_e                            : dump FSM state encoding
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        DUMP_IDLE    = 2'd0,
        DUMP_SCAN    = 2'd1,
        DUMP_PRESENT = 2'd2,
        DUMP_DONE    = 2'd3
    } dump_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
// Valid/ready stream carrying register dump beats out of regfile_mp.
//   dump_valid : beat present (source -> sink)
//   dump_ready : sink accepts the beat this cycle (sink -> source)
//   dump_addr  : register index of the beat
//   dump_data  : register contents captured when the beat was loaded
// Modports: master = the register file (source), slave = the consumer.
// -----------------------------------------------------------------------------
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();

    logic                  dump_valid;
    logic                  dump_ready;
    logic [ADDR_WIDTH-1:0] dump_addr;
    logic [DATA_WIDTH-1:0] dump_data;

    modport master (
        output dump_valid,
        output dump_addr,
        output dump_data,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_addr,
        input  dump_data,
        output dump_ready
    );

endinterface

// File: rtl/regfile_dump_fsm.sv
// -----------------------------------------------------------------------------
// regfile_dump_fsm
// Walks an inclusive register range and streams (index, value) beats.
//   clock, ctrl_reset       : clock, asynchronous active-high reset
//   dump_start              : start pulse, honoured only when idle
//   dump_dirty_only         : 1 = emit only registers whose dirty bit is set
//   dump_first, dump_last   : inclusive range, latched at start
//   dirty                   : dirty vector from the storage block
//   ptr_data                : stored (non-bypassed) value of register ptr
//   ptr                     : current scan pointer
//   clr_en, clr_addr        : clear request for the dirty bit of an accepted beat
//   dump_busy, dump_done    : status; dump_done is a one-cycle pulse
//   dump_if                 : beat stream (master side)
// -----------------------------------------------------------------------------
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                         clock,
    input  logic                         ctrl_reset,
    input  logic                         dump_start,
    input  logic                         dump_dirty_only,
    input  logic [ADDR_WIDTH-1:0]        dump_first,
    input  logic [ADDR_WIDTH-1:0]        dump_last,
    input  logic [(2**ADDR_WIDTH)-1:0]   dirty,
    input  logic [DATA_WIDTH-1:0]        ptr_data,
    output logic [ADDR_WIDTH-1:0]        ptr,
    output logic                         clr_en,
    output logic [ADDR_WIDTH-1:0]        clr_addr,
    output logic                         dump_busy,
    output logic                         dump_done,
    regfile_mp_if.master                 dump_if
);

    dump_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, first_q, last_q, addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  mode_q;
    logic                  valid;

    logic range_empty;
    logic qualify;
    logic at_last;

    assign range_empty = first_q > last_q;
    assign qualify     = !mode_q || dirty[ptr_q];
    assign at_last     = ptr_q == last_q;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) state_q <= DUMP_IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: the default assignment at the top keeps every path assigned, so no
    // latch is inferred from the incomplete case arms below.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DUMP_IDLE:    if (dump_start) state_d = DUMP_SCAN;
            DUMP_SCAN: begin
                if (range_empty)  state_d = DUMP_DONE;
                else if (qualify) state_d = DUMP_PRESENT;
                else if (at_last) state_d = DUMP_DONE;
            end
            DUMP_PRESENT: begin
                if (dump_if.dump_ready) state_d = at_last ? DUMP_DONE : DUMP_SCAN;
            end
            DUMP_DONE:    state_d = DUMP_IDLE;
            default:      state_d = DUMP_IDLE;
        endcase
    end

    // Outputs decoded from state; reset forces IDLE so they drop immediately.
    always_comb begin
        valid     = 1'b0;
        dump_busy = 1'b0;
        dump_done = 1'b0;
        clr_en    = 1'b0;
        case (state_q)
            DUMP_SCAN:    dump_busy = 1'b1;
            DUMP_PRESENT: begin
                dump_busy = 1'b1;
                valid     = 1'b1;
                clr_en    = dump_if.dump_ready;
            end
            DUMP_DONE: begin
                dump_busy = 1'b1;
                dump_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Range/mode capture, pointer advance and beat registers. The beat is
    // captured from the stored array, so later writes to that register never
    // disturb a beat that is being held under backpressure. The pointer only
    // advances while it is below last, so it can never wrap.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            ptr_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            mode_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                DUMP_IDLE: begin
                    if (dump_start) begin
                        first_q <= dump_first;
                        last_q  <= dump_last;
                        mode_q  <= dump_dirty_only;
                        ptr_q   <= dump_first;
                    end
                end
                DUMP_SCAN: begin
                    if (!range_empty) begin
                        if (qualify) begin
                            addr_q <= ptr_q;
                            data_q <= ptr_data;
                        end else if (!at_last) begin
                            ptr_q <= ptr_q + 1'b1;
                        end
                    end
                end
                DUMP_PRESENT: begin
                    if (dump_if.dump_ready && !at_last) ptr_q <= ptr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ptr                = ptr_q;
    assign clr_addr           = addr_q;
    assign dump_if.dump_valid = valid;
    assign dump_if.dump_addr  = addr_q;
    assign dump_if.dump_data  = data_q;

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// 2**ADDR_WIDTH x DATA_WIDTH register file, two combinational read ports with
// write bypass, one write port, per-register dirty bits and a dump engine that
// streams a register range (optionally only dirty registers).
//   clock, ctrl_reset                          : clock, async active-high reset
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg : write port (reg 0 ignored)
//   ctrl_readRegA/B -> data_readRegA/B         : read ports, bypassed
//   ctrl_dumpStart/DirtyOnly/First/Last        : dump control
//   dump_if                                    : dump beat stream (master)
//   dump_busy, dump_done                       : dump status
//   dirty                                      : one dirty bit per register
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                       clock,
    input  logic                       ctrl_reset,
    input  logic                       ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0]      ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0]      data_writeReg,
    input  logic [ADDR_WIDTH-1:0]      ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0]      ctrl_readRegB,
    output logic [DATA_WIDTH-1:0]      data_readRegA,
    output logic [DATA_WIDTH-1:0]      data_readRegB,
    input  logic                       ctrl_dumpStart,
    input  logic                       ctrl_dumpDirtyOnly,
    input  logic [ADDR_WIDTH-1:0]      ctrl_dumpFirst,
    input  logic [ADDR_WIDTH-1:0]      ctrl_dumpLast,
    regfile_mp_if.master               dump_if,
    output logic                       dump_busy,
    output logic                       dump_done,
    output logic [(2**ADDR_WIDTH)-1:0] dirty
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   dirty_q;
    logic                  wr_commit;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DATA_WIDTH-1:0] ptr_data;
    logic                  clr_en;
    logic [ADDR_WIDTH-1:0] clr_addr;

    assign wr_commit = ctrl_writeEnable && (ctrl_writeReg != '0);

    // Storage. Register 0 is never written, so it stays at its reset value 0.
    // NOTE: the array is cleared by reset because the block must read all zeros
    // straight after reset; this costs a reset net on every storage flop.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_commit) begin
            regs[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Dirty bits. The set is written after the clear so that a write landing
    // on the register being accepted by the dump in the same cycle wins.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            dirty_q <= '0;
        end else begin
            if (clr_en)    dirty_q[clr_addr]      <= 1'b0;
            if (wr_commit) dirty_q[ctrl_writeReg] <= 1'b1;
        end
    end

    assign dirty = dirty_q;

    // Read ports with write-through bypass for a write in flight this cycle.
    always_comb begin
        data_readRegA = regs[ctrl_readRegA];
        if (wr_commit && (ctrl_writeReg == ctrl_readRegA)) data_readRegA = data_writeReg;
    end

    always_comb begin
        data_readRegB = regs[ctrl_readRegB];
        if (wr_commit && (ctrl_writeReg == ctrl_readRegB)) data_readRegB = data_writeReg;
    end

    // Dump engine samples the stored value, deliberately without bypass.
    assign ptr_data = regs[ptr];

    regfile_dump_fsm #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dump_fsm (
        .clock           (clock),
        .ctrl_reset      (ctrl_reset),
        .dump_start      (ctrl_dumpStart),
        .dump_dirty_only (ctrl_dumpDirtyOnly),
        .dump_first      (ctrl_dumpFirst),
        .dump_last       (ctrl_dumpLast),
        .dirty           (dirty_q),
        .ptr_data        (ptr_data),
        .ptr             (ptr),
        .clr_en          (clr_en),
        .clr_addr        (clr_addr),
        .dump_busy       (dump_busy),
        .dump_done       (dump_done),
        .dump_if         (dump_if)
    );

endmodule
